// File: rtl/p3_pkg.sv
// ---------------------------------------------------------------------------
// p3_pkg
// Shared definitions for the pattern count engine:
//   - default data-memory layout (message, pattern byte, result bytes)
//   - controller state encoding
//   - count_t, the 8-bit type used for all three result counters
// ---------------------------------------------------------------------------
package p3_pkg;

  localparam logic [7:0] DEF_STR_BASE = 8'd128;  // first message byte
  localparam logic [7:0] DEF_PAT_ADDR = 8'd160;  // pattern byte, pattern in [7:3]
  localparam logic [7:0] DEF_RES_BASE = 8'd192;  // ctb, cto, cts at +0, +1, +2
  localparam int         DEF_NBYTES   = 32;      // counter widths assume 32

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RD_PAT,
    RD_STR,
    WR_CTB,
    WR_CTO,
    WR_CTS,
    FINISH
  } state_e;

  typedef logic [7:0] count_t;

endpackage

// File: rtl/pattern_window_match.sv
// ---------------------------------------------------------------------------
// pattern_window_match
// Combinational 5-bit pattern matcher over a 12-bit window
// {prev[3:0], cur[7:0]}.
//   win_i        : 12-bit window, current byte in [7:0]
//   pat_i        : 5-bit pattern
//   first_byte_i : 1 = first message byte, only the 4 in-byte windows count
//                  toward x_cnt_o (there is no previous byte)
//   in_cnt_o     : matches among cur[7:3], cur[6:2], cur[5:1], cur[4:0] (0..4)
//   in_any_o     : at least one in-byte match
//   x_cnt_o      : string-count contribution, the 8 windows whose lsb lies in
//                  cur (0..8), or the in-byte count when first_byte_i is set
// ---------------------------------------------------------------------------
module pattern_window_match
  import p3_pkg::*;
(
  input  logic [11:0] win_i,
  input  logic [4:0]  pat_i,
  input  logic        first_byte_i,
  output logic [2:0]  in_cnt_o,
  output logic        in_any_o,
  output logic [3:0]  x_cnt_o
);

  // hit[gi] : window with its lsb at bit gi; gi 0..3 lie wholly inside cur,
  // gi 4..7 straddle the previous byte.
  logic [7:0] hit;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_win
      assign hit[gi] = (win_i[gi+4:gi] == pat_i);
    end
  endgenerate

  logic [3:0] cross_cnt;

  always_comb begin
    in_cnt_o  = {2'b00, hit[0]} + {2'b00, hit[1]} + {2'b00, hit[2]} + {2'b00, hit[3]};
    in_any_o  = |hit[3:0];
    cross_cnt = {1'b0, in_cnt_o} + {3'b000, hit[4]} + {3'b000, hit[5]}
              + {3'b000, hit[6]} + {3'b000, hit[7]};
    x_cnt_o   = first_byte_i ? {1'b0, in_cnt_o} : cross_cnt;
  end

endmodule

// File: rtl/pattern_count_engine.sv
// ---------------------------------------------------------------------------
// pattern_count_engine
// START/DONE responder that counts 5-bit pattern occurrences in a 32-byte
// message held in data memory and writes the three counts back.
//   CLK          : clock, rising edge
//   RESET_N      : asynchronous active-low reset
//   START        : high = hold idle / abort; run begins when START goes low
//   DONE         : high once results are written, until START rises again
//   MEM_ADDR     : data memory address
//   MEM_RD_EN    : read strobe, data returns on MEM_RD_DATA the next cycle
//   MEM_RD_DATA  : read data
//   MEM_WR_EN    : write strobe, one byte per cycle
//   MEM_WR_DATA  : write data
// Run timeline (cycle 0 = first cycle in RD_PAT):
//   0 read pattern, 1..32 read message, 2..33 consume byte i-2,
//   34..36 write ctb/cto/cts, 37+ DONE.
// All outputs are registers loaded from the next-state decode.
// ---------------------------------------------------------------------------
module pattern_count_engine
  import p3_pkg::*;
#(
  parameter logic [7:0] STR_BASE = DEF_STR_BASE,
  parameter int         NBYTES   = DEF_NBYTES,
  parameter logic [7:0] PAT_ADDR = DEF_PAT_ADDR,
  parameter logic [7:0] RES_BASE = DEF_RES_BASE
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  output logic       DONE,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_RD_EN,
  input  logic [7:0] MEM_RD_DATA,
  output logic       MEM_WR_EN,
  output logic [7:0] MEM_WR_DATA
);

  localparam logic [5:0] LAST_RD_CYC   = 6'(NBYTES);      // last message read
  localparam logic [5:0] LAST_CONS_CYC = 6'(NBYTES + 1);  // last byte consumed

  state_e     state_q, state_d;
  logic [5:0] cyc_q, cyc_d;
  logic [4:0] pat_q, pat_d;
  logic [3:0] prev_q, prev_d;
  count_t     ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
  logic       done_q, done_d;
  logic [7:0] addr_q, addr_d;
  logic       rd_en_q, rd_en_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [2:0] in_cnt;
  logic       in_any;
  logic [3:0] x_cnt;

  pattern_window_match u_match (
    .win_i        ({prev_q, MEM_RD_DATA}),
    .pat_i        (pat_q),
    .first_byte_i (cyc_q == 6'd2),
    .in_cnt_o     (in_cnt),
    .in_any_o     (in_any),
    .x_cnt_o      (x_cnt)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pat_d   = pat_q;
    prev_d  = prev_q;
    ctb_d   = ctb_q;
    cto_d   = cto_q;
    cts_d   = cts_q;

    case (state_q)
      IDLE: begin
        if (START) state_d = ARMED;
      end
      ARMED: begin
        if (!START) begin
          state_d = RD_PAT;
          cyc_d   = 6'd0;
          prev_d  = 4'd0;
          ctb_d   = '0;
          cto_d   = '0;
          cts_d   = '0;
        end
      end
      RD_PAT: begin
        state_d = RD_STR;
        cyc_d   = 6'd1;
      end
      RD_STR: begin
        cyc_d = cyc_q + 6'd1;
        // Data read in cycle 0 (pattern byte) arrives in cycle 1.
        if (cyc_q == 6'd1) pat_d = MEM_RD_DATA[7:3];
        if (cyc_q >= 6'd2) begin
          prev_d = MEM_RD_DATA[3:0];
          ctb_d  = ctb_q + {5'b0, in_cnt};
          cto_d  = cto_q + {7'b0, in_any};
          cts_d  = cts_q + {4'b0, x_cnt};
        end
        if (cyc_q == LAST_CONS_CYC) state_d = WR_CTB;
      end
      WR_CTB:  state_d = WR_CTO;
      WR_CTO:  state_d = WR_CTS;
      WR_CTS:  state_d = FINISH;
      FINISH:  state_d = FINISH;
      default: state_d = IDLE;
    endcase

    // START high outside IDLE/ARMED abandons the run (or acknowledges DONE).
    if (START && state_q != IDLE && state_q != ARMED) begin
      state_d = ARMED;
      ctb_d   = '0;
      cto_d   = '0;
      cts_d   = '0;
    end
  end

  // Output decode from the next state so every output is a clean register.
  always_comb begin
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = 8'd0;
    wr_data_d = 8'd0;
    done_d    = (state_d == FINISH);
    case (state_d)
      RD_PAT: begin
        rd_en_d = 1'b1;
        addr_d  = PAT_ADDR;
      end
      RD_STR: begin
        if (cyc_d <= LAST_RD_CYC) begin
          rd_en_d = 1'b1;
          addr_d  = STR_BASE + {2'b00, cyc_d} - 8'd1;
        end
      end
      WR_CTB: begin
        wr_en_d   = 1'b1;
        addr_d    = RES_BASE;
        wr_data_d = ctb_d;
      end
      WR_CTO: begin
        wr_en_d   = 1'b1;
        addr_d    = RES_BASE + 8'd1;
        wr_data_d = cto_d;
      end
      WR_CTS: begin
        wr_en_d   = 1'b1;
        addr_d    = RES_BASE + 8'd2;
        wr_data_d = cts_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      cyc_q     <= 6'd0;
      pat_q     <= 5'd0;
      prev_q    <= 4'd0;
      ctb_q     <= '0;
      cto_q     <= '0;
      cts_q     <= '0;
      done_q    <= 1'b0;
      addr_q    <= 8'd0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      pat_q     <= pat_d;
      prev_q    <= prev_d;
      ctb_q     <= ctb_d;
      cto_q     <= cto_d;
      cts_q     <= cts_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign DONE        = done_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_RD_EN   = rd_en_q;
  assign MEM_WR_EN   = wr_en_q;
  assign MEM_WR_DATA = wr_data_q;

endmodule

// File: tb/tb_pattern_count_engine.sv
// ---------------------------------------------------------------------------
// tb_pattern_count_engine
// Directed and randomised bench for pattern_count_engine with a 256-byte
// synchronous data memory model. Message/pattern image is owned by the
// stimulus side; the memory process records DUT writes into res[].
// ---------------------------------------------------------------------------
module tb_pattern_count_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  always #5 clk = ~clk;

  pattern_count_engine dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .START       (start),
    .DONE        (done),
    .MEM_ADDR    (mem_addr),
    .MEM_RD_EN   (mem_rd_en),
    .MEM_RD_DATA (mem_rd_data),
    .MEM_WR_EN   (mem_wr_en),
    .MEM_WR_DATA (mem_wr_data)
  );

  // Memory image, results and write bookkeeping
  logic [7:0] img [256];
  logic [7:0] res [3];
  logic       clr_res = 1'b0;
  logic       bad_wr;
  int         wr_pulses;

  always @(posedge clk) begin
    if (clr_res) begin
      res[0]    <= 8'hFF;
      res[1]    <= 8'hFF;
      res[2]    <= 8'hFF;
      bad_wr    <= 1'b0;
      wr_pulses <= 0;
    end else if (mem_wr_en) begin
      wr_pulses <= wr_pulses + 1;
      if (mem_addr >= 8'd192 && mem_addr <= 8'd194) res[mem_addr - 8'd192] <= mem_wr_data;
      else bad_wr <= 1'b1;
    end
    if (mem_rd_en) mem_rd_data <= img[mem_addr];
  end

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Observations from the last run_dut call
  int obs_proto_err;
  int obs_first_done;

  task automatic fill(input logic [7:0] pat_byte, input logic [7:0] fill_byte);
    img[160] = pat_byte;
    for (int i = 0; i < 32; i++) img[128+i] = fill_byte;
  endtask

  task automatic clear_results();
    @(posedge clk); #1 clr_res = 1'b1;
    @(posedge clk); #1 clr_res = 1'b0;
  endtask

  // Arms the DUT, drops START and follows the run for 42 cycles, recording
  // strobe-timing deviations and the cycle at which DONE first rises.
  task automatic run_dut();
    logic exp_rd, exp_wr, exp_done;
    clear_results();
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b0;
    obs_proto_err  = 0;
    obs_first_done = -1;
    for (int c = 0; c < 42; c++) begin
      @(posedge clk); #1;
      exp_rd   = (c <= 32);
      exp_wr   = (c >= 34 && c <= 36);
      exp_done = (c >= 37);
      if (mem_rd_en !== exp_rd || mem_wr_en !== exp_wr || done !== exp_done) obs_proto_err++;
      if (done === 1'b1 && obs_first_done < 0) obs_first_done = c;
    end
  endtask

  // Behavioural model on the 256-bit MSB-first string.
  task automatic model(output logic [7:0] ctb, output logic [7:0] cto, output logic [7:0] cts);
    logic [255:0] s;
    logic [4:0]   p;
    int           n;
    p = img[160][7:3];
    for (int i = 0; i < 32; i++) s[255-8*i -: 8] = img[128+i];
    ctb = 0; cto = 0; cts = 0;
    for (int k = 0; k <= 251; k++) if (s[255-k -: 5] == p) cts++;
    for (int b = 0; b < 32; b++) begin
      n = 0;
      for (int o = 0; o < 4; o++) if (s[255-(8*b+o) -: 5] == p) n++;
      ctb = ctb + 8'(n);
      if (n > 0) cto++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    vec_cnt++;
    if ({done, mem_rd_en, mem_wr_en} !== 3'b000 || mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
      miss_cnt++;
      $display("FAIL reset_outputs: got done=%b rd=%b wr=%b addr=%0d wdata=%0d, expected all 0",
               done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data);
    end
    @(negedge clk) rst_n = 1'b1;
    $display("reset: outputs idle");
  endtask

  task automatic test_zeros();
    fill(8'h00, 8'h00);
    run_dut();
    $display("zeros: ctb=%0d cto=%0d cts=%0d first_done=%0d", res[0], res[1], res[2], obs_first_done);
    vec_cnt++;
    if (obs_proto_err !== 0) begin
      miss_cnt++;
      $display("FAIL zeros_strobes: %0d cycles with wrong rd/wr/done, expected 0", obs_proto_err);
    end
    vec_cnt++;
    if (obs_first_done !== 37) begin
      miss_cnt++;
      $display("FAIL zeros_done_cycle: got %0d, expected 37", obs_first_done);
    end
    vec_cnt++;
    if (res[0] !== 8'd128 || res[1] !== 8'd32 || res[2] !== 8'd252) begin
      miss_cnt++;
      $display("FAIL zeros_counts: got %0d/%0d/%0d, expected 128/32/252", res[0], res[1], res[2]);
    end
    vec_cnt++;
    if (bad_wr !== 1'b0 || wr_pulses !== 3) begin
      miss_cnt++;
      $display("FAIL zeros_writes: bad_wr=%b pulses=%0d, expected 0 and 3", bad_wr, wr_pulses);
    end
  endtask

  task automatic test_done_hold();
    int drops = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b1) drops++;
    end
    vec_cnt++;
    if (drops !== 0) begin
      miss_cnt++;
      $display("FAIL done_hold: DONE low in %0d cycles, expected 0", drops);
    end
    start = 1'b1;
    @(posedge clk); #1;
    $display("done_hold: done after START=%b", done);
    vec_cnt++;
    if (done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL done_release: got %b, expected 0", done);
    end
  endtask

  task automatic test_alt();
    fill(8'hA8, 8'h55);  // pat = 10101
    run_dut();
    $display("alt55: ctb=%0d cto=%0d cts=%0d", res[0], res[1], res[2]);
    vec_cnt++;
    if (res[0] !== 8'd64 || res[1] !== 8'd32 || res[2] !== 8'd126 || obs_proto_err !== 0) begin
      miss_cnt++;
      $display("FAIL alt55_counts: got %0d/%0d/%0d proto=%0d, expected 64/32/126 proto=0",
               res[0], res[1], res[2], obs_proto_err);
    end
  endtask

  task automatic test_crossing();
    fill(8'hF8, 8'h00);  // pat = 11111
    img[128] = 8'h0F;
    img[129] = 8'hF0;
    run_dut();
    $display("crossing: ctb=%0d cto=%0d cts=%0d", res[0], res[1], res[2]);
    vec_cnt++;
    if (res[0] !== 8'd0 || res[1] !== 8'd0 || res[2] !== 8'd4) begin
      miss_cnt++;
      $display("FAIL crossing_counts: got %0d/%0d/%0d, expected 0/0/4", res[0], res[1], res[2]);
    end
  endtask

  task automatic test_random();
    logic [7:0] e_ctb, e_cto, e_cts;
    for (int seed = 0; seed < 200; seed++) begin
      img[160] = 8'($urandom);
      // Mix fully random bytes with a sparse alphabet to provoke matches.
      for (int i = 0; i < 32; i++)
        img[128+i] = (seed % 2 == 0) ? 8'($urandom) : (($urandom_range(1) == 1) ? img[160] : 8'h00);
      model(e_ctb, e_cto, e_cts);
      run_dut();
      $display("random %0d: pat=%02h got %0d/%0d/%0d model %0d/%0d/%0d",
               seed, img[160][7:3], res[0], res[1], res[2], e_ctb, e_cto, e_cts);
      vec_cnt++;
      if (res[0] !== e_ctb || res[1] !== e_cto || res[2] !== e_cts) begin
        miss_cnt++;
        $display("FAIL random_counts seed %0d: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                 seed, res[0], res[1], res[2], e_ctb, e_cto, e_cts);
      end
      vec_cnt++;
      if (bad_wr !== 1'b0 || wr_pulses !== 3 || obs_proto_err !== 0) begin
        miss_cnt++;
        $display("FAIL random_writes seed %0d: bad_wr=%b pulses=%0d proto=%0d, expected 0/3/0",
                 seed, bad_wr, wr_pulses, obs_proto_err);
      end
    end
  endtask

  task automatic test_abort();
    int done_seen = 0;
    fill(8'h00, 8'h00);
    clear_results();
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;  // sampled at the end of cycle 10
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    $display("abort: writes=%0d done_cycles=%0d", wr_pulses, done_seen);
    vec_cnt++;
    if (wr_pulses !== 0 || done_seen !== 0) begin
      miss_cnt++;
      $display("FAIL abort_quiet: writes=%0d done_cycles=%0d, expected 0/0", wr_pulses, done_seen);
    end
    fill(8'hA8, 8'h55);
    run_dut();
    $display("after_abort: ctb=%0d cto=%0d cts=%0d", res[0], res[1], res[2]);
    vec_cnt++;
    if (res[0] !== 8'd64 || res[1] !== 8'd32 || res[2] !== 8'd126 || obs_first_done !== 37) begin
      miss_cnt++;
      $display("FAIL after_abort_counts: got %0d/%0d/%0d done@%0d, expected 64/32/126 done@37",
               res[0], res[1], res[2], obs_first_done);
    end
  endtask

  task automatic test_async_reset();
    logic rd_before;
    fill(8'h00, 8'h00);
    clear_results();
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
    end
    rd_before = mem_rd_en;
    rst_n = 1'b0;  // mid-cycle, no clock edge until checked
    #1;
    $display("async_reset: rd before=%b, after done=%b rd=%b wr=%b", rd_before, done, mem_rd_en, mem_wr_en);
    vec_cnt++;
    if (rd_before !== 1'b1 || {done, mem_rd_en, mem_wr_en} !== 3'b000) begin
      miss_cnt++;
      $display("FAIL async_reset: rd_before=%b outs=%b, expected 1 and 000",
               rd_before, {done, mem_rd_en, mem_wr_en});
    end
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    fill(8'h00, 8'h00);
    run_dut();
    $display("after_reset: ctb=%0d cto=%0d cts=%0d", res[0], res[1], res[2]);
    vec_cnt++;
    if (res[0] !== 8'd128 || res[1] !== 8'd32 || res[2] !== 8'd252 || obs_proto_err !== 0) begin
      miss_cnt++;
      $display("FAIL after_reset_counts: got %0d/%0d/%0d proto=%0d, expected 128/32/252 proto=0",
               res[0], res[1], res[2], obs_proto_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    test_reset();
    test_zeros();
    test_done_hold();
    test_alt();
    test_crossing();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
